tilegen_layer_mixer: RTL and testbench
======================================

# tilegen_layer_mixer

Parametrised N-layer tile priority compositor: successor to the fixed two-chip, two-layers-per-chip priority cascade in the tile generation subsystem. Accepts per-pixel colour/dot codes from NUM_LAYERS tile layers. Resolves the visible pixel through a registered per-layer compare pipeline using CPU-programmable priorities and enables, plus a background colour. Emits priority, colour, dot and the tile palette PROM address. Register updates are double-buffered and committed at vertical sync, so priority changes never tear mid-frame.

## Interface
Parameters:
- NUM_LAYERS, 4: tile layers composited (1..8).
- COLOR_W, 8: colour code width per layer.
- DOT_W, 3: dot (pixel index) width per layer.
- PRI_W, 3: priority width.
- TRANSPARENT_DOT, 7: dot value treated as transparent.
- LAYER_DISABLE_MASK, 0: bit i set disables layer i at reset.
- DEFAULT_PRIORITY, 0: packed NUM_LAYERS×PRI_W reset priorities, layer i at [i*PRI_W +: PRI_W].
- SYNC_UPDATE, 1: 1 commits shadow registers at nVSYNC falling edge; 0 makes writes take effect immediately.

Ports:
- CLK_6M in 1: pixel clock, one pixel per cycle.
- rst in 1: synchronous, active-high reset.
- nVSYNC in 1: vertical sync, active low.
- cpu_cs in 1: register select.
- cpu_we in 1: write strobe, qualified by cpu_cs.
- cpu_addr in AW: register address, AW = clog2(NUM_LAYERS+1).
- cpu_din in 8: write data.
- cpu_dout out 8: shadow register readback (combinational).
- layer_cl in NUM_LAYERS×COLOR_W: per-layer colour, layer i at [i*COLOR_W +: COLOR_W].
- layer_dt in NUM_LAYERS×DOT_W: per-layer dot.
- PRO out PRI_W: winning priority.
- CLO out COLOR_W: winning colour.
- DTO out DOT_W: winning dot.
- pal_addr out COLOR_W+DOT_W: {CLO, DTO}, to palette PROM.
- win_idx out AW: winning layer index; NUM_LAYERS means background.
- out_valid out 1: pipeline holds real pixels.

## Operation
- Register map:
  - addr i < NUM_LAYERS: bit7 = enable, bits[PRI_W-1:0] = priority.
  - addr NUM_LAYERS: background colour (low COLOR_W bits).
  - Other addresses: writes ignored, reads 0.
  - Unused bits read 0.
- Shadow and active sets:
  - CPU writes the shadow set.
  - Active set <= shadow on the cycle the registered nVSYNC edge detector sees 1→0 (SYNC_UPDATE=1), or every cycle (SYNC_UPDATE=0).
  - Write coincident with a commit: commit copies the pre-write shadow; the new value lands at the next vsync.
- Reset:
  - Shadow and active priorities = DEFAULT_PRIORITY; enable = ~LAYER_DISABLE_MASK; background = 0.
  - All outputs 0 except win_idx = NUM_LAYERS; out_valid = 0.
- Stage 0 seed: {pri 0, background colour, dot all-ones, idx NUM_LAYERS}.
- Stage i replaces the incoming candidate with layer i when all of the following hold:
  - active enable[i] is set;
  - dt_i != TRANSPARENT_DOT;
  - pri_i >= incoming pri.
- Ties go to the higher layer index. A disabled or transparent layer passes the candidate unchanged.
- Layer i inputs are skewed internally by i registers, so the caller presents all layers aligned in the same cycle.
- The priority values used by a pixel are sampled from the active set when that pixel enters stage 0. A commit mid-pipeline does not alter pixels already in flight.

## Timing
- Latency is NUM_LAYERS+1 cycles: NUM_LAYERS compare stages plus an output register. Inputs at cycle t appear on outputs at t+NUM_LAYERS+1.
- Throughput is 1 pixel/cycle; no stall.
- out_valid: a fill counter rises 0..NUM_LAYERS+1 after reset; out_valid = 1 once it saturates and stays 1 until the next rst.
- Commit takes effect for pixels entering at the cycle after the edge is detected, i.e. 2 cycles after nVSYNC falls (1 sync register plus 1 commit).
- Reset mid-operation clears the pipeline, the fill counter and both register sets within the same cycle.
- cpu_dout reflects a write on the following cycle.

## Structure
- Shared header tilegen_mixer.vh holds:
  - the AW computation macro;
  - register offsets (REG_LAYER_BASE = 0, REG_BACKCOLOR = NUM_LAYERS);
  - the enable bit position (7);
  - the candidate field ordering {pri, cl, dt, idx}.
- Sub-module tilegen_mix_stage: one registered compare stage with the layer input skew. It is instantiated NUM_LAYERS times in a generate loop.
- Top level holds the register file, the vsync edge detector, the fill counter and the output register.

## Test plan
- Reset, then idle: every output is 0, win_idx = 4, out_valid = 0 for 5 cycles and 1 from cycle 5.
- Priorities L0..L3 = 1,2,3,4, all layers enabled, all dt = 0, cl = 0x10,0x20,0x30,0x40: after 5 cycles CLO = 0x40, PRO = 4, win_idx = 3, pal_addr = 0x200.
- As above with L3 dt = 7: CLO = 0x30, win_idx = 2. With every layer dt = 7 and backcolour 0x55: CLO = 0x55, DTO = 7, PRO = 0, win_idx = 4.
- Tie: L1 and L2 both priority 5, both opaque: win_idx = 2.
- SYNC_UPDATE = 1: write addr 3 = 0x00 (disable L3) mid-frame; output unchanged until nVSYNC falls, then L2 wins for pixels entering 2 cycles later. A write in the commit cycle is deferred to the next vsync.
- Readback: write 0x85 to addr 1, read 0x85; write to addr 7 has no effect and reads 0.

Source files
------------

// File: rtl/tilegen_layer_mixer_pkg.sv
// Shared constants for the tile layer mixer: register map layout and address sizing.
package tilegen_layer_mixer_pkg;

    localparam int unsigned RegLayerBase = 0;
    localparam int unsigned EnableBit    = 7;
    localparam int unsigned CpuDataW     = 8;

    // Address space covers one register per layer plus the background colour.
    function automatic int unsigned addr_width(input int unsigned num_layers);
        return $clog2(num_layers + 1);
    endfunction

endpackage

// File: rtl/tilegen_mix_stage.sv
// One registered priority-compare stage; the layer input is delayed by Idx registers so that
// it meets the candidate travelling down the pipeline.
module tilegen_mix_stage
    import tilegen_layer_mixer_pkg::*;
#(
    parameter int unsigned Idx            = 0,
    parameter int unsigned NumLayers      = 4,
    parameter int unsigned ColorW         = 8,
    parameter int unsigned DotW           = 3,
    parameter int unsigned PriW           = 3,
    parameter int unsigned AwW            = 3,
    parameter int unsigned TransparentDot = 7,
    localparam int unsigned CandW         = PriW + ColorW + DotW + AwW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CandW-1:0]  cand_i,
    input  logic [ColorW-1:0] layer_cl_i,
    input  logic [DotW-1:0]   layer_dt_i,
    input  logic [PriW-1:0]   layer_pri_i,
    input  logic              layer_en_i,
    output logic [CandW-1:0]  cand_o
);

    localparam int unsigned LayW = 1 + PriW + ColorW + DotW;
    localparam logic [CandW-1:0] CandReset = {{(CandW - AwW){1'b0}}, AwW'(NumLayers)};

    logic [LayW-1:0]   lay_in;
    logic [LayW-1:0]   lay;
    logic              lay_en;
    logic [PriW-1:0]   lay_pri;
    logic [ColorW-1:0] lay_cl;
    logic [DotW-1:0]   lay_dt;
    logic [PriW-1:0]   in_pri;
    logic [CandW-1:0]  cand_d;
    logic [CandW-1:0]  cand_q;

    // Priority and enable ride the skew chain so they stay bound to the pixel they were
    // sampled with at stage 0.
    assign lay_in = {layer_en_i, layer_pri_i, layer_cl_i, layer_dt_i};

    if (Idx == 0) begin : g_no_skew
        assign lay = lay_in;
    end else begin : g_skew
        logic [LayW-1:0] skew_d [Idx];
        logic [LayW-1:0] skew_q [Idx];

        always_comb begin
            skew_d[0] = lay_in;
            for (int j = 1; j < Idx; j++) begin
                skew_d[j] = skew_q[j-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int j = 0; j < Idx; j++) begin
                    skew_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j < Idx; j++) begin
                    skew_q[j] <= skew_d[j];
                end
            end
        end

        assign lay = skew_q[Idx-1];
    end

    assign {lay_en, lay_pri, lay_cl, lay_dt} = lay;
    assign in_pri = cand_i[CandW-1 -: PriW];

    always_comb begin
        cand_d = cand_i;
        if (lay_en && (lay_dt != DotW'(TransparentDot)) && (lay_pri >= in_pri)) begin
            cand_d = {lay_pri, lay_cl, lay_dt, AwW'(Idx)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_q <= CandReset;
        end else begin
            cand_q <= cand_d;
        end
    end

    assign cand_o = cand_q;

endmodule

// File: rtl/tilegen_layer_mixer.sv
// N-layer tile priority compositor: double-buffered CPU register file committed at vsync,
// a chain of compare stages seeded with the background colour, and an output register.
module tilegen_layer_mixer
    import tilegen_layer_mixer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS                       = 4,
    parameter int unsigned COLOR_W                          = 8,
    parameter int unsigned DOT_W                            = 3,
    parameter int unsigned PRI_W                            = 3,
    parameter int unsigned TRANSPARENT_DOT                  = 7,
    parameter logic [NUM_LAYERS-1:0]       LAYER_DISABLE_MASK = '0,
    parameter logic [NUM_LAYERS*PRI_W-1:0] DEFAULT_PRIORITY   = '0,
    parameter bit          SYNC_UPDATE                      = 1'b1
) (
    input  logic                                  CLK_6M,
    input  logic                                  rst,
    input  logic                                  nVSYNC,
    input  logic                                  cpu_cs,
    input  logic                                  cpu_we,
    input  logic [addr_width(NUM_LAYERS)-1:0]     cpu_addr,
    input  logic [CpuDataW-1:0]                   cpu_din,
    output logic [CpuDataW-1:0]                   cpu_dout,
    input  logic [NUM_LAYERS*COLOR_W-1:0]         layer_cl,
    input  logic [NUM_LAYERS*DOT_W-1:0]           layer_dt,
    output logic [PRI_W-1:0]                      PRO,
    output logic [COLOR_W-1:0]                    CLO,
    output logic [DOT_W-1:0]                      DTO,
    output logic [COLOR_W+DOT_W-1:0]              pal_addr,
    output logic [addr_width(NUM_LAYERS)-1:0]     win_idx,
    output logic                                  out_valid
);

    localparam int unsigned AW = addr_width(NUM_LAYERS);
    localparam int unsigned CW = PRI_W + COLOR_W + DOT_W + AW;
    localparam int unsigned FW = $clog2(NUM_LAYERS + 2);
    localparam logic [CW-1:0] CandReset = {{(CW - AW){1'b0}}, AW'(NUM_LAYERS)};
    localparam logic [FW-1:0] FillFull  = FW'(NUM_LAYERS + 1);

    logic [NUM_LAYERS*PRI_W-1:0] sh_pri_d, sh_pri_q, act_pri_d, act_pri_q;
    logic [NUM_LAYERS-1:0]       sh_en_d, sh_en_q, act_en_d, act_en_q;
    logic [COLOR_W-1:0]          sh_bg_d, sh_bg_q, act_bg_d, act_bg_q;
    logic                        vs_q, vs_qq;
    logic                        commit;
    logic [FW-1:0]               fill_d, fill_q;
    logic [CW-1:0]               out_q;
    logic [CW-1:0]               cand [NUM_LAYERS+1];

    // Shadow register file writes.
    always_comb begin
        sh_pri_d = sh_pri_q;
        sh_en_d  = sh_en_q;
        sh_bg_d  = sh_bg_q;
        if (cpu_cs && cpu_we) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (cpu_addr == AW'(RegLayerBase + i)) begin
                    sh_en_d[i]                  = cpu_din[EnableBit];
                    sh_pri_d[i*PRI_W +: PRI_W]  = cpu_din[PRI_W-1:0];
                end
            end
            if (cpu_addr == AW'(NUM_LAYERS)) begin
                sh_bg_d = cpu_din[COLOR_W-1:0];
            end
        end
    end

    always_comb begin
        cpu_dout = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cpu_addr == AW'(RegLayerBase + i)) begin
                cpu_dout[EnableBit]  = sh_en_q[i];
                cpu_dout[PRI_W-1:0]  = sh_pri_q[i*PRI_W +: PRI_W];
            end
        end
        if (cpu_addr == AW'(NUM_LAYERS)) begin
            cpu_dout[COLOR_W-1:0] = sh_bg_q;
        end
    end

    // Commit copies the pre-write shadow, so a write landing on the commit edge waits a frame.
    assign commit = SYNC_UPDATE ? (vs_qq & ~vs_q) : 1'b1;

    always_comb begin
        act_pri_d = commit ? sh_pri_q : act_pri_q;
        act_en_d  = commit ? sh_en_q  : act_en_q;
        act_bg_d  = commit ? sh_bg_q  : act_bg_q;
        fill_d    = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
    end

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            sh_pri_q  <= DEFAULT_PRIORITY;
            sh_en_q   <= ~LAYER_DISABLE_MASK;
            sh_bg_q   <= '0;
            act_pri_q <= DEFAULT_PRIORITY;
            act_en_q  <= ~LAYER_DISABLE_MASK;
            act_bg_q  <= '0;
            vs_q      <= 1'b1;
            vs_qq     <= 1'b1;
            fill_q    <= '0;
            out_q     <= CandReset;
        end else begin
            sh_pri_q  <= sh_pri_d;
            sh_en_q   <= sh_en_d;
            sh_bg_q   <= sh_bg_d;
            act_pri_q <= act_pri_d;
            act_en_q  <= act_en_d;
            act_bg_q  <= act_bg_d;
            vs_q      <= nVSYNC;
            vs_qq     <= vs_q;
            fill_q    <= fill_d;
            out_q     <= cand[NUM_LAYERS];
        end
    end

    assign cand[0] = {{PRI_W{1'b0}}, act_bg_q, {DOT_W{1'b1}}, AW'(NUM_LAYERS)};

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_stage
        tilegen_mix_stage #(
            .Idx            (g),
            .NumLayers      (NUM_LAYERS),
            .ColorW         (COLOR_W),
            .DotW           (DOT_W),
            .PriW           (PRI_W),
            .AwW            (AW),
            .TransparentDot (TRANSPARENT_DOT)
        ) u_stage (
            .clk_i       (CLK_6M),
            .rst_i       (rst),
            .cand_i      (cand[g]),
            .layer_cl_i  (layer_cl[g*COLOR_W +: COLOR_W]),
            .layer_dt_i  (layer_dt[g*DOT_W +: DOT_W]),
            .layer_pri_i (act_pri_q[g*PRI_W +: PRI_W]),
            .layer_en_i  (act_en_q[g]),
            .cand_o      (cand[g+1])
        );
    end

    assign PRO       = out_q[CW-1 -: PRI_W];
    assign CLO       = out_q[AW+DOT_W +: COLOR_W];
    assign DTO       = out_q[AW +: DOT_W];
    assign win_idx   = out_q[AW-1:0];
    assign pal_addr  = {CLO, DTO};
    assign out_valid = (fill_q == FillFull);

endmodule

// File: tb/tb_tilegen_layer_mixer.sv
// Directed bench for tilegen_layer_mixer: vector table of layer setups plus vsync timing,
// deferred-write, readback and reset sequences.
module tb_tilegen_layer_mixer;

    logic        clk;
    logic        rst;
    logic        nvs;
    logic        cs;
    logic        we;
    logic [2:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [31:0] lcl;
    logic [11:0] ldt;
    logic [2:0]  pro;
    logic [7:0]  clo;
    logic [2:0]  dto;
    logic [10:0] pal;
    logic [2:0]  idx;
    logic        valid;

    int total = 0;
    int bad   = 0;

    tilegen_layer_mixer dut (
        .CLK_6M    (clk),
        .rst       (rst),
        .nVSYNC    (nvs),
        .cpu_cs    (cs),
        .cpu_we    (we),
        .cpu_addr  (addr),
        .cpu_din   (din),
        .cpu_dout  (dout),
        .layer_cl  (lcl),
        .layer_dt  (ldt),
        .PRO       (pro),
        .CLO       (clo),
        .DTO       (dto),
        .pal_addr  (pal),
        .win_idx   (idx),
        .out_valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pri;
        logic [3:0]  en;
        logic [7:0]  bg;
        logic [31:0] cl;
        logic [11:0] dt;
        logic [2:0]  pro;
        logic [7:0]  clo;
        logic [2:0]  dto;
        logic [2:0]  idx;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        tick();
        cs = 1'b0; we = 1'b0; din = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        cs = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(name, dout, exp);
        cs = 1'b0;
    endtask

    task automatic vsync_pulse();
        nvs = 1'b0;
        tick();
        tick();
        nvs = 1'b1;
        tick();
        tick();
    endtask

    task automatic cfg(input logic [11:0] p, input logic [3:0] e, input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            wr(3'(i), {e[i], 4'b0000, p[i*3 +: 3]});
        end
        wr(3'd4, b);
        vsync_pulse();
    endtask

    initial begin
        vecs[0] = '{{3'd4, 3'd3, 3'd2, 3'd1}, 4'hF, 8'h00, 32'h40302010,
                    {3'd0, 3'd0, 3'd0, 3'd0}, 3'd4, 8'h40, 3'd0, 3'd3};
        vecs[1] = '{{3'd4, 3'd3, 3'd2, 3'd1}, 4'hF, 8'h00, 32'h40302010,
                    {3'd7, 3'd0, 3'd0, 3'd0}, 3'd3, 8'h30, 3'd0, 3'd2};
        vecs[2] = '{{3'd4, 3'd3, 3'd2, 3'd1}, 4'hF, 8'h55, 32'h40302010,
                    {3'd7, 3'd7, 3'd7, 3'd7}, 3'd0, 8'h55, 3'd7, 3'd4};
        vecs[3] = '{{3'd0, 3'd5, 3'd5, 3'd0}, 4'hF, 8'h00, 32'h40302010,
                    {3'd0, 3'd0, 3'd0, 3'd0}, 3'd5, 8'h30, 3'd0, 3'd2};
        vecs[4] = '{{3'd0, 3'd1, 3'd2, 3'd6}, 4'hF, 8'h00, 32'h40302010,
                    {3'd4, 3'd3, 3'd2, 3'd1}, 3'd6, 8'h10, 3'd1, 3'd0};
        vecs[5] = '{{3'd4, 3'd3, 3'd2, 3'd1}, 4'h7, 8'h00, 32'h40302010,
                    {3'd0, 3'd0, 3'd0, 3'd0}, 3'd3, 8'h30, 3'd0, 3'd2};
        vecs[6] = '{{3'd0, 3'd0, 3'd0, 3'd0}, 4'hF, 8'h00, 32'h40302010,
                    {3'd4, 3'd3, 3'd2, 3'd1}, 3'd0, 8'h40, 3'd4, 3'd3};
        vecs[7] = '{{3'd4, 3'd3, 3'd2, 3'd1}, 4'h0, 8'hAA, 32'h40302010,
                    {3'd0, 3'd0, 3'd0, 3'd0}, 3'd0, 8'hAA, 3'd7, 3'd4};
        vecs[8] = '{{3'd7, 3'd7, 3'd7, 3'd7}, 4'hF, 8'h00, 32'h40302010,
                    {3'd7, 3'd0, 3'd0, 3'd0}, 3'd7, 8'h30, 3'd0, 3'd2};

        rst = 1'b1; nvs = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
        lcl = '0; ldt = 12'hFFF;
        repeat (3) tick();
        rst = 1'b0;

        // Reset values hold while the pipeline drains; valid rises on cycle 5.
        for (int c = 0; c <= 5; c++) begin
            if (c < 5) begin
                chk($sformatf("rst_valid_c%0d", c), valid, 0);
                chk($sformatf("rst_pro_c%0d", c), pro, 0);
                chk($sformatf("rst_clo_c%0d", c), clo, 0);
                chk($sformatf("rst_dto_c%0d", c), dto, 0);
                chk($sformatf("rst_idx_c%0d", c), idx, 4);
            end else begin
                chk("rst_valid_c5", valid, 1);
            end
            tick();
        end

        for (int v = 0; v < 9; v++) begin
            cfg(vecs[v].pri, vecs[v].en, vecs[v].bg);
            lcl = vecs[v].cl;
            ldt = vecs[v].dt;
            repeat (8) tick();
            chk($sformatf("v%0d_pro", v), pro, vecs[v].pro);
            chk($sformatf("v%0d_clo", v), clo, vecs[v].clo);
            chk($sformatf("v%0d_dto", v), dto, vecs[v].dto);
            chk($sformatf("v%0d_idx", v), idx, vecs[v].idx);
            chk($sformatf("v%0d_pal", v), pal, {vecs[v].clo, vecs[v].dto});
            chk($sformatf("v%0d_valid", v), valid, 1);
        end

        // Mid-frame shadow write must not reach the pixels until vsync.
        cfg({3'd4, 3'd3, 3'd2, 3'd1}, 4'hF, 8'h00);
        lcl = 32'h40302010;
        ldt = '0;
        repeat (8) tick();
        chk("vs_before", idx, 3);
        wr(3'd3, 8'h00);
        repeat (10) tick();
        chk("vs_hold", idx, 3);
        nvs = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 2) nvs = 1'b1;
            if (n == 6) chk("vs_last_old", idx, 3);
            if (n == 7) chk("vs_first_new", idx, 2);
        end

        // Write landing on the commit edge is deferred to the following vsync.
        repeat (4) tick();
        nvs = 1'b0;
        tick();
        wr(3'd3, 8'h84);
        nvs = 1'b1;
        rd_chk("defer_shadow", 3'd3, 8'h84);
        repeat (10) tick();
        chk("defer_idx", idx, 2);
        vsync_pulse();
        repeat (8) tick();
        chk("defer_next_idx", idx, 3);
        chk("defer_next_pro", pro, 4);

        // Readback and unmapped address.
        wr(3'd1, 8'h85);
        rd_chk("rb_a1", 3'd1, 8'h85);
        wr(3'd2, 8'h7E);
        rd_chk("rb_a2_unused", 3'd2, 8'h06);
        wr(3'd4, 8'h5A);
        rd_chk("rb_bg", 3'd4, 8'h5A);
        wr(3'd7, 8'hFF);
        rd_chk("rb_a7", 3'd7, 8'h00);
        rd_chk("rb_a1_after_a7", 3'd1, 8'h85);

        // Mid-operation reset clears pipeline, fill counter and both register sets.
        rst = 1'b1;
        tick();
        chk("mrst_valid", valid, 0);
        chk("mrst_idx", idx, 4);
        chk("mrst_pro", pro, 0);
        chk("mrst_clo", clo, 0);
        rd_chk("mrst_sh_a1", 3'd1, 8'h80);
        rd_chk("mrst_sh_bg", 3'd4, 8'h00);
        rst = 1'b0;
        lcl = 32'h40302010;
        ldt = '0;
        repeat (8) tick();
        chk("mrst_act_pro", pro, 0);
        chk("mrst_act_idx", idx, 3);
        chk("mrst_act_clo", clo, 8'h40);
        ldt = 12'hFFF;
        repeat (8) tick();
        chk("mrst_act_bg", clo, 8'h00);
        chk("mrst_act_bg_idx", idx, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
